// File: rtl/swu_stream_if.sv
// swu_stream_if -- stream bundle for the sliding-window unit.
//   start      : frame start request (producer -> unit)
//   in_data    : one sample per lane, lane k at [k*DATA_W +: DATA_W]
//   in_val     : input beat valid; in_rdy : unit ready to accept
//   slide_data : windowed sample per lane, same packing as in_data
//   data_val   : output beat valid; out_rdy : consumer ready
//   win_last   : final beat of a window
//   trans_done : one-cycle end-of-frame pulse
//   busy       : unit is not idle
// Modport slave is the unit itself; master is the producer/consumer side.
interface swu_stream_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 7
);
    logic                     start;
    logic [N_CH*DATA_W-1:0]   in_data;
    logic                     in_val;
    logic                     in_rdy;
    logic [N_CH*DATA_W-1:0]   slide_data;
    logic                     data_val;
    logic                     out_rdy;
    logic                     win_last;
    logic                     trans_done;
    logic                     busy;

    modport slave (
        input  start, in_data, in_val, out_rdy,
        output in_rdy, slide_data, data_val, win_last, trans_done, busy
    );

    modport master (
        output start, in_data, in_val, out_rdy,
        input  in_rdy, slide_data, data_val, win_last, trans_done, busy
    );
endinterface

// File: rtl/swu_stream.sv
// swu_stream -- sliding-window streamer for N_CH lockstep ECG lanes.
// A frame of FRAME_LEN samples is cut into NUM_WIN overlapping windows of
// WIN_LEN samples spaced STRIDE apart. The first window is filled, then each
// window is replayed oldest-first; between windows STRIDE new samples
// overwrite the oldest entries of a per-lane circular buffer.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : swu_stream_if.slave (start, input/output handshakes,
//                win_last, trans_done, busy)
module swu_stream #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 7,
    parameter int WIN_LEN   = 16,
    parameter int STRIDE    = 4,
    parameter int FRAME_LEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    swu_stream_if.slave   bus
);
    localparam int NUM_WIN = (FRAME_LEN - WIN_LEN) / STRIDE + 1;
    localparam int BUS_W   = N_CH * DATA_W;
    localparam int PTR_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int CNT_W   = $clog2(WIN_LEN + 1);
    localparam int WCNT_W  = $clog2(NUM_WIN + 1);

    typedef enum logic [2:0] {IDLE, FILL, EMIT, SLIDE, DONE} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d, beat_cnt_q, beat_cnt_d;
    logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [BUS_W-1:0]    buf_q [WIN_LEN];

    logic                wr_en, in_rdy, data_val, win_last, trans_done;
    logic [CNT_W-1:0]    acc_last;

    // Pointers wrap explicitly so non-power-of-two WIN_LEN also works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(WIN_LEN - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Fill needs a whole window of accepts, a slide only STRIDE of them.
    assign acc_last = (state_q == FILL) ? CNT_W'(WIN_LEN - 1) : CNT_W'(STRIDE - 1);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        acc_cnt_d  = acc_cnt_q;
        beat_cnt_d = beat_cnt_q;
        win_cnt_d  = win_cnt_q;
        wr_en      = 1'b0;
        in_rdy     = 1'b0;
        data_val   = 1'b0;
        win_last   = 1'b0;
        trans_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = FILL;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    acc_cnt_d  = '0;
                    beat_cnt_d = '0;
                    win_cnt_d  = '0;
                end
            end
            FILL, SLIDE: begin
                in_rdy = 1'b1;
                if (bus.in_val) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                    if (acc_cnt_q == acc_last) begin
                        // After the write, the next write slot holds the oldest sample.
                        acc_cnt_d  = '0;
                        beat_cnt_d = '0;
                        rd_ptr_d   = ptr_inc(wr_ptr_q);
                        state_d    = EMIT;
                    end else begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                data_val = 1'b1;
                win_last = (beat_cnt_q == CNT_W'(WIN_LEN - 1));
                if (bus.out_rdy) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    if (win_last) begin
                        beat_cnt_d = '0;
                        win_cnt_d  = win_cnt_q + 1'b1;
                        state_d    = (win_cnt_q == WCNT_W'(NUM_WIN - 1)) ? DONE : SLIDE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                trans_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            acc_cnt_q  <= '0;
            beat_cnt_q <= '0;
            win_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            acc_cnt_q  <= acc_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            win_cnt_q  <= win_cnt_d;
        end
    end

    // Sample storage is never read before being written within a frame,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.in_rdy     = in_rdy;
    assign bus.data_val   = data_val;
    assign bus.win_last   = win_last;
    assign bus.trans_done = trans_done;
    assign bus.busy       = (state_q != IDLE);
    assign bus.slide_data = data_val ? buf_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_swu_stream.sv
// tb_swu_stream -- directed bench for swu_stream.
// Three instances: default (STRIDE 4), non-overlapping (STRIDE 16) and
// single-step (STRIDE 1, FRAME_LEN 20). Each has a sample source whose lane k
// carries (sample_index + 16*k) mod 128 and advances only on an accept, so
// the expected beat for window w, beat b is sample w*STRIDE + b.
module tb_swu_stream;
    localparam int NL = 4;
    localparam int DW = 7;
    localparam int BW = NL * DW;

    logic clk = 1'b0;
    logic rst_n;
    logic in_val, out_rdy;
    logic [2:0] start_s, fclr;
    int   fcnt [3];
    int   n_chk = 0;
    int   n_err = 0;

    logic [2:0]    dv, ir, wl, td, bs;
    logic [BW-1:0] sd [3];

    always #5 clk = ~clk;

    swu_stream_if #(.N_CH(NL), .DATA_W(DW)) if0 ();
    swu_stream_if #(.N_CH(NL), .DATA_W(DW)) if1 ();
    swu_stream_if #(.N_CH(NL), .DATA_W(DW)) if2 ();

    swu_stream #(.N_CH(NL), .DATA_W(DW), .WIN_LEN(16), .STRIDE(4),  .FRAME_LEN(64))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    swu_stream #(.N_CH(NL), .DATA_W(DW), .WIN_LEN(16), .STRIDE(16), .FRAME_LEN(64))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    swu_stream #(.N_CH(NL), .DATA_W(DW), .WIN_LEN(16), .STRIDE(1),  .FRAME_LEN(20))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    function automatic logic [BW-1:0] mk(input int s);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < NL; k++) v[k*DW +: DW] = DW'(s + 16 * k);
        return v;
    endfunction

    assign if0.start = start_s[0]; assign if0.in_val = in_val; assign if0.out_rdy = out_rdy;
    assign if1.start = start_s[1]; assign if1.in_val = in_val; assign if1.out_rdy = out_rdy;
    assign if2.start = start_s[2]; assign if2.in_val = in_val; assign if2.out_rdy = out_rdy;
    assign if0.in_data = mk(fcnt[0]);
    assign if1.in_data = mk(fcnt[1]);
    assign if2.in_data = mk(fcnt[2]);

    assign dv = {if2.data_val,   if1.data_val,   if0.data_val};
    assign ir = {if2.in_rdy,     if1.in_rdy,     if0.in_rdy};
    assign wl = {if2.win_last,   if1.win_last,   if0.win_last};
    assign td = {if2.trans_done, if1.trans_done, if0.trans_done};
    assign bs = {if2.busy,       if1.busy,       if0.busy};
    assign sd[0] = if0.slide_data;
    assign sd[1] = if1.slide_data;
    assign sd[2] = if2.slide_data;

    // Sample sources: index advances once per accepted beat.
    always @(posedge clk) begin
        if (fclr[0]) fcnt[0] <= 0; else if (in_val && ir[0]) fcnt[0] <= fcnt[0] + 1;
        if (fclr[1]) fcnt[1] <= 0; else if (in_val && ir[1]) fcnt[1] <= fcnt[1] + 1;
        if (fclr[2]) fcnt[2] <= 0; else if (in_val && ir[2]) fcnt[2] <= fcnt[2] + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode bits: 1 = random out_rdy, 2 = input stalls, 4 = start while busy,
    //            8 = reset abort in window 2
    task automatic run_frame(input int sel, input int mode);
        int stride, nw, flen;
        int w = 0, b = 0, tdn = 0, stall_left = 0;
        bit st1 = 0, st2 = 0, sb1 = 0, sb2 = 0, pend = 0, done = 0, hold = 0;
        logic [BW-1:0] hsd;
        logic          hwl;
        case (sel)
            1:       begin stride = 16; flen = 64; end
            2:       begin stride = 1;  flen = 20; end
            default: begin stride = 4;  flen = 64; end
        endcase
        nw = (flen - 16) / stride + 1;
        hsd = '0;
        hwl = 1'b0;

        @(negedge clk);
        in_val = 1'b1; out_rdy = 1'b1;
        fclr[sel] = 1'b1; start_s[sel] = 1'b1;
        @(negedge clk);
        fclr[sel] = 1'b0; start_s[sel] = 1'b0;
        chk("busy_after_start", bs[sel], 1);
        chk("inrdy_in_fill", ir[sel], 1);

        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            out_rdy = ((mode & 1) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            start_s[sel] = 1'b0;
            if ((mode & 2) != 0) begin
                if (stall_left == 0 && !st1 && fcnt[sel] == 8)  begin st1 = 1; stall_left = 5; end
                if (stall_left == 0 && !st2 && fcnt[sel] == 18) begin st2 = 1; stall_left = 5; end
                in_val = (stall_left == 0);
                if (stall_left > 0) begin
                    stall_left--;
                    chk("stall_inrdy_held", ir[sel], 1);
                end
            end
            if ((mode & 4) != 0) begin
                if (!sb1 && dv[sel] && w == 0 && b == 3) begin start_s[sel] = 1'b1; sb1 = 1; end
                if (!sb2 && ir[sel] && w == 1)           begin start_s[sel] = 1'b1; sb2 = 1; end
            end
            if ((mode & 8) != 0 && dv[sel] && w == 2 && b == 5) begin
                rst_n = 1'b0;
                #1;
                chk("abort_dv",   dv[sel], 0);
                chk("abort_ir",   ir[sel], 0);
                chk("abort_wl",   wl[sel], 0);
                chk("abort_td",   td[sel], 0);
                chk("abort_busy", bs[sel], 0);
                chk("abort_sd",   sd[sel], 0);
                chk("abort_no_td_seen", tdn, 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_stays_idle", bs[sel], 0);
                return;
            end
            #1;
            if (hold) begin
                chk("stall_dv", dv[sel], 1);
                chk("stall_sd", sd[sel], hsd);
                chk("stall_wl", wl[sel], hwl);
            end
            if (dv[sel] && out_rdy) begin
                chk("beat_data", sd[sel], mk(w * stride + b));
                chk("beat_last", wl[sel], (b == 15));
                chk("emit_inrdy", ir[sel], 0);
                b++;
                if (b == 16) begin b = 0; w++; end
            end
            hold = ((mode & 1) != 0) && dv[sel] && !out_rdy;
            hsd  = sd[sel];
            hwl  = wl[sel];
            if (pend) begin
                chk("td_one_cycle", td[sel], 0);
                chk("idle_after_done", bs[sel], 0);
                done = 1;
            end else if (td[sel]) begin
                tdn++;
                chk("done_windows", w, nw);
                chk("done_inrdy", ir[sel], 0);
                chk("done_dv", dv[sel], 0);
                pend = 1;
            end
            if (!done) @(negedge clk);
        end
        in_val = 1'b1;
        chk("frame_finished", done, 1);
        chk("trans_done_count", tdn, 1);
        chk("windows_emitted", w, nw);
        chk("samples_consumed", fcnt[sel], flen);
        if ((mode & 2) != 0) chk("stalls_applied", {st1, st2}, 2'b11);
        if ((mode & 4) != 0) chk("busy_starts_applied", {sb1, sb2}, 2'b11);
    endtask

    initial begin
        rst_n = 1'b0; in_val = 1'b1; out_rdy = 1'b1; start_s = '0; fclr = '0;
        repeat (3) @(negedge clk);
        chk("rst_inrdy", ir[0], 0);
        chk("rst_dv",    dv[0], 0);
        chk("rst_wl",    wl[0], 0);
        chk("rst_td",    td[0], 0);
        chk("rst_busy",  bs[0], 0);
        chk("rst_sd",    sd[0], 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start_inrdy", ir[0], 0);
        chk("idle_no_start_busy",  bs[0], 0);

        run_frame(0, 0);   // nominal
        run_frame(0, 1);   // output backpressure
        run_frame(0, 2);   // input stalls in FILL and SLIDE
        run_frame(0, 4);   // start pulses while busy
        run_frame(0, 8);   // reset abort mid-frame
        run_frame(0, 0);   // full frame after abort
        run_frame(1, 0);   // STRIDE = WIN_LEN
        run_frame(2, 0);   // STRIDE = 1, short frame
        run_frame(2, 1);   // short frame with backpressure

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
